// File: rtl/nasti_lite_reader_pkg.sv
// Shared types and helpers for the NASTI -> NASTI-lite read bridge.
// Holds AXI burst/response encodings, the fixed-width part of a NASTI read request
// and the arithmetic helpers used to split bursts into lite reads.
package nasti_lite_reader_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Fixed-width AR attributes; id/addr/user widths are parameters of the top,
  // so those fields are wrapped around this struct there.
  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
  } nasti_attr_t;

  // Number of lite reads needed for one NASTI beat of 2**size bytes.
  function automatic logic [5:0] lite_packet_ratio(input logic [2:0] size,
                                                   input logic [2:0] lite_w_bits);
    if (size > lite_w_bits) return 6'd1 << (size - lite_w_bits);
    return 6'd1;
  endfunction

  // Address step between consecutive lite reads: min(2**size, lite bytes).
  function automatic logic [7:0] lite_step_size(input logic [2:0] size,
                                                input logic [2:0] lite_w_bits);
    return (size < lite_w_bits) ? (8'd1 << size) : (8'd1 << lite_w_bits);
  endfunction

  // Address of the cnt-th lite read of an INCR burst.
  function automatic logic [63:0] incr(input logic [63:0] base,
                                       input logic [15:0] cnt,
                                       input logic [7:0]  step);
    return base + 64'(cnt) * 64'(step);
  endfunction

endpackage

// File: rtl/nasti_lite_req_fifo.sv
// Circular buffer of NASTI read requests (wp/rp plus a non-empty flag).
// Ports: clk/rstn; push_i + push_dat_i write; pop_i reads pop_dat_o (head, valid when
// !empty_o); full_o / empty_o status. Push and pop may coincide.
module nasti_lite_req_fifo
  import nasti_lite_reader_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = logic
) (
  input  logic clk,
  input  logic rstn,
  input  logic push_i,
  input  T     push_dat_i,
  input  logic pop_i,
  output T     pop_dat_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wp_q, wp_d, rp_q, rp_d;
  logic             vld_q, vld_d;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o   = !vld_q;
  // With equal pointers the flag tells a full ring from an empty one.
  assign full_o    = vld_q && (wp_q == rp_q);
  assign pop_dat_o = mem_q[rp_q];

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    vld_d = vld_q;
    if (push_i) wp_d = ptr_next(wp_q);
    if (pop_i)  rp_d = ptr_next(rp_q);
    if (push_i && !pop_i)                               vld_d = 1'b1;
    else if (pop_i && !push_i && ptr_next(rp_q) == wp_q) vld_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp_q  <= '0;
      rp_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      vld_q <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wp_q] <= push_dat_i;
  end

endmodule

// File: rtl/nasti_lite_reader.sv
// NASTI -> NASTI-lite read bridge: splits INCR bursts into single lite reads and packs
// the lite R words back into NASTI beats. Ports: nasti_ar_*_i/ready_o (burst in),
// nasti_r_*_o/ready_i (beats out), lite_ar_*_o/ready_i, lite_r_*_i/ready_o.
// Macro NASTI_LITE_READER_STICKY_ERR_EN: beat resp is the worst sub-read resp, else the last.
module nasti_lite_reader
  import nasti_lite_reader_pkg::*;
#(
  parameter int MAX_TRANSACTION  = 2,
  parameter int ID_WIDTH         = 1,
  parameter int ADDR_WIDTH       = 8,
  parameter int NASTI_DATA_WIDTH = 64,
  parameter int LITE_DATA_WIDTH  = 32,
  parameter int USER_WIDTH       = 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [ID_WIDTH-1:0]         nasti_ar_id_i,
  input  logic [ADDR_WIDTH-1:0]       nasti_ar_addr_i,
  input  logic [7:0]                  nasti_ar_len_i,
  input  logic [2:0]                  nasti_ar_size_i,
  input  logic [1:0]                  nasti_ar_burst_i,
  input  logic                        nasti_ar_lock_i,
  input  logic [3:0]                  nasti_ar_cache_i,
  input  logic [2:0]                  nasti_ar_prot_i,
  input  logic [3:0]                  nasti_ar_qos_i,
  input  logic [3:0]                  nasti_ar_region_i,
  input  logic [USER_WIDTH-1:0]       nasti_ar_user_i,
  input  logic                        nasti_ar_valid_i,
  output logic                        nasti_ar_ready_o,
  output logic [ID_WIDTH-1:0]         nasti_r_id_o,
  output logic [NASTI_DATA_WIDTH-1:0] nasti_r_data_o,
  output logic [1:0]                  nasti_r_resp_o,
  output logic                        nasti_r_last_o,
  output logic [USER_WIDTH-1:0]       nasti_r_user_o,
  output logic                        nasti_r_valid_o,
  input  logic                        nasti_r_ready_i,
  output logic [ID_WIDTH-1:0]         lite_ar_id_o,
  output logic [ADDR_WIDTH-1:0]       lite_ar_addr_o,
  output logic [2:0]                  lite_ar_prot_o,
  output logic [3:0]                  lite_ar_qos_o,
  output logic [3:0]                  lite_ar_region_o,
  output logic [USER_WIDTH-1:0]       lite_ar_user_o,
  output logic                        lite_ar_valid_o,
  input  logic                        lite_ar_ready_i,
  input  logic [ID_WIDTH-1:0]         lite_r_id_i,
  input  logic [LITE_DATA_WIDTH-1:0]  lite_r_data_i,
  input  logic [1:0]                  lite_r_resp_i,
  input  logic [USER_WIDTH-1:0]       lite_r_user_i,
  input  logic                        lite_r_valid_i,
  output logic                        lite_r_ready_o
);

  localparam int LITE_W_BITS = $clog2(LITE_DATA_WIDTH / 8);
  localparam int NLANES      = NASTI_DATA_WIDTH / LITE_DATA_WIDTH;
  localparam int LANE_W      = (NLANES > 1) ? $clog2(NLANES) : 1;

  if (LITE_DATA_WIDTH != 32 && LITE_DATA_WIDTH != 64) begin : g_bad_lite_width
    $fatal(1, "LITE_DATA_WIDTH must be 32 or 64");
  end
  if (NASTI_DATA_WIDTH < LITE_DATA_WIDTH) begin : g_bad_nasti_width
    $fatal(1, "NASTI_DATA_WIDTH must be >= LITE_DATA_WIDTH");
  end
  if (USER_WIDTH < 1) begin : g_bad_user_width
    $fatal(1, "USER_WIDTH must be > 0");
  end

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    nasti_attr_t           attr;
    logic [USER_WIDTH-1:0] user;
  } nasti_req_t;

  nasti_req_t ar_req, fifo_dat;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;

  assign ar_req = '{id: nasti_ar_id_i, addr: nasti_ar_addr_i, user: nasti_ar_user_i,
                    attr: '{len: nasti_ar_len_i, size: nasti_ar_size_i,
                            burst: nasti_ar_burst_i, lock: nasti_ar_lock_i,
                            cache: nasti_ar_cache_i, prot: nasti_ar_prot_i,
                            qos: nasti_ar_qos_i, region: nasti_ar_region_i}};

  assign nasti_ar_ready_o = !fifo_full;
  assign fifo_push        = nasti_ar_valid_i && nasti_ar_ready_o;

  nasti_lite_req_fifo #(.DEPTH(MAX_TRANSACTION), .T(nasti_req_t)) u_req_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .push_i     (fifo_push),
    .push_dat_i (ar_req),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rstn && fifo_push && nasti_ar_burst_i != BURST_INCR)
      $fatal(1, "nasti_lite_reader: only INCR bursts are supported");
  end

  nasti_req_t                              xact_q, xact_d;
  logic                                    xact_vld_q, xact_vld_d;
  logic [15:0]                             lite_cnt_q, lite_cnt_d;
  logic [5:0]                              sub_cnt_q, sub_cnt_d;
  logic [7:0]                              beat_cnt_q, beat_cnt_d;
  logic                                    pend_q, pend_d;
  logic                                    beat_full_q, beat_full_d;
  logic [LANE_W-1:0]                       lane_q, lane_d;
  logic [NLANES-1:0][LITE_DATA_WIDTH-1:0]  beat_q, beat_d;
  logic [1:0]                              resp_q, resp_d;

  logic [5:0]            ratio;
  logic [7:0]            step;
  logic [15:0]           total;
  logic [ADDR_WIDTH-1:0] lite_addr;
  logic                  lite_ar_hs, lite_r_hs, nasti_r_hs, last_beat;

  assign ratio     = lite_packet_ratio(xact_q.attr.size, 3'(LITE_W_BITS));
  assign step      = lite_step_size(xact_q.attr.size, 3'(LITE_W_BITS));
  assign total     = 16'(ratio) * (16'(xact_q.attr.len) + 16'd1);
  assign lite_addr = ADDR_WIDTH'(incr(64'(xact_q.addr), lite_cnt_q, step));
  assign last_beat = (beat_cnt_q == xact_q.attr.len);

  // One lite read in flight at a time, and none while a packed beat waits for the master.
  assign lite_ar_valid_o = xact_vld_q && !pend_q && !beat_full_q && (lite_cnt_q < total);
  assign lite_ar_hs      = lite_ar_valid_o && lite_ar_ready_i;
  assign lite_r_ready_o  = pend_q;
  assign lite_r_hs       = pend_q && lite_r_valid_i;
  assign nasti_r_hs      = beat_full_q && nasti_r_ready_i;
  // Reload in the cycle the final beat leaves so back-to-back bursts see no bubble.
  assign fifo_pop        = !fifo_empty && (!xact_vld_q || (nasti_r_hs && last_beat));

  always_comb begin
    xact_d      = xact_q;
    xact_vld_d  = xact_vld_q;
    lite_cnt_d  = lite_cnt_q;
    sub_cnt_d   = sub_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    pend_d      = pend_q;
    beat_full_d = beat_full_q;
    lane_d      = lane_q;
    beat_d      = beat_q;
    resp_d      = resp_q;

    if (lite_ar_hs) begin
      lite_cnt_d = lite_cnt_q + 16'd1;
      pend_d     = 1'b1;
      // Lane is the address slice between lite and NASTI word boundaries.
      lane_d     = (NLANES > 1) ? LANE_W'(lite_addr >> LITE_W_BITS) : '0;
    end

    if (lite_r_hs) begin
      pend_d         = 1'b0;
      beat_d[lane_q] = lite_r_data_i;
`ifdef NASTI_LITE_READER_STICKY_ERR_EN
      resp_d = (sub_cnt_q == 6'd0 || lite_r_resp_i > resp_q) ? lite_r_resp_i : resp_q;
`else
      resp_d = lite_r_resp_i;
`endif
      if (sub_cnt_q == ratio - 6'd1) begin
        sub_cnt_d   = 6'd0;
        beat_full_d = 1'b1;
      end else begin
        sub_cnt_d = sub_cnt_q + 6'd1;
      end
    end

    if (nasti_r_hs) begin
      beat_full_d = 1'b0;
      if (last_beat) begin
        beat_cnt_d = 8'd0;
        lite_cnt_d = 16'd0;
        xact_vld_d = 1'b0;
      end else begin
        beat_cnt_d = beat_cnt_q + 8'd1;
      end
    end

    if (fifo_pop) begin
      xact_vld_d = 1'b1;
      xact_d     = fifo_dat;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      xact_q      <= '0;
      xact_vld_q  <= 1'b0;
      lite_cnt_q  <= '0;
      sub_cnt_q   <= '0;
      beat_cnt_q  <= '0;
      pend_q      <= 1'b0;
      beat_full_q <= 1'b0;
      lane_q      <= '0;
      beat_q      <= '0;
      resp_q      <= RESP_OKAY;
    end else begin
      xact_q      <= xact_d;
      xact_vld_q  <= xact_vld_d;
      lite_cnt_q  <= lite_cnt_d;
      sub_cnt_q   <= sub_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      pend_q      <= pend_d;
      beat_full_q <= beat_full_d;
      lane_q      <= lane_d;
      beat_q      <= beat_d;
      resp_q      <= resp_d;
    end
  end

  assign lite_ar_id_o     = xact_q.id;
  assign lite_ar_addr_o   = lite_addr;
  assign lite_ar_prot_o   = xact_q.attr.prot;
  assign lite_ar_qos_o    = xact_q.attr.qos;
  assign lite_ar_region_o = xact_q.attr.region;
  assign lite_ar_user_o   = xact_q.user;

  assign nasti_r_valid_o = beat_full_q;
  assign nasti_r_data_o  = beat_q;
  assign nasti_r_resp_o  = resp_q;
  assign nasti_r_last_o  = last_beat;
  assign nasti_r_id_o    = xact_q.id;
  assign nasti_r_user_o  = xact_q.user;

  // Lite slaves reply in order with one read outstanding, so id/user carry no information.
  logic unused_ok;
  assign unused_ok = ^{xact_q.attr.burst, xact_q.attr.lock, xact_q.attr.cache,
                       lite_r_id_i, lite_r_user_i};

endmodule
